// File: rtl/dec38_scan_pkg.sv
// Shared definitions for the dec38 scan sequencer: state encoding and slot geometry.
package dec38_scan_pkg;

  // Number of decoder outputs being scanned and the width of a slot index.
  localparam int N_SLOTS = 8;
  localparam int SLOT_W  = 3;

  // Sequencer states. Encoding is fixed so the debug port is stable across builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

endpackage : dec38_scan_pkg

// File: rtl/dec38_next_slot.sv
// Wrap-around priority search: finds the first set mask bit strictly above
// cur, wrapping through bit 0 and ending at cur itself.
module dec38_next_slot
  import dec38_scan_pkg::*;
(
  input  logic [N_SLOTS-1:0] mask,
  input  logic [SLOT_W-1:0]  cur,
  output logic [SLOT_W-1:0]  nxt,
  output logic               wrap,
  output logic               none
);

  logic              w_found;
  logic [SLOT_W-1:0] w_idx;

  // Walk the eight candidates in scan order (cur+1 ... cur+8 modulo 8) and keep the first hit.
  always_comb begin
    w_found = 1'b0;
    nxt     = cur;
    w_idx   = cur;
    for (int i = 1; i <= N_SLOTS; i++) begin
      w_idx = cur + SLOT_W'(i);
      if (!w_found && mask[w_idx]) begin
        w_found = 1'b1;
        nxt     = w_idx;
      end
    end
  end

  // An empty mask has no next slot; otherwise a result at or below cur means the scan wrapped.
  assign none = ~|mask;
  assign wrap = w_found && (nxt <= cur);

endmodule : dec38_next_slot

// File: rtl/dec38_scan_ctrl.sv
// Scan sequencer driving a dec38 decoder: steps through the enabled slots in
// ascending order, blanking en for a fixed interval before every slot and
// holding each slot for a programmable dwell time.
//
// Handshake: start is a level request honoured only in IDLE (and only when
// mask has a set bit); stop is a level abort honoured in BLANK and DRIVE and
// beats every other event in the same cycle. There is no ready/ack; busy
// reports that a scan is in progress.
//
// BLANK_CYCLES must lie in 1..15 (the blank counter is 4 bits wide).
module dec38_scan_ctrl
  import dec38_scan_pkg::*;
#(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N_SLOTS-1:0] mask,
  output logic [SLOT_W-1:0]  a,
  output logic               en,
  output logic               busy,
  output logic               frame_done,
  output logic [1:0]         o_dbg_state
);

  localparam logic [3:0] BLANK_INIT = 4'(BLANK_CYCLES - 1);

  state_t             r_state;
  logic [SLOT_W-1:0]  r_a;
  logic               r_en;
  logic               r_busy;
  logic               r_frame_done;
  logic [3:0]         r_blank_cnt;
  logic [DWELL_W-1:0] r_dwell_cnt;

  logic [SLOT_W-1:0]  w_cur;
  logic [SLOT_W-1:0]  w_nxt;
  logic               w_wrap;
  logic               w_none;

  // In IDLE, searching from slot 7 yields the lowest set bit, so one search
  // unit serves both the first slot of a scan and the slot-to-slot step.
  assign w_cur = (r_state == ST_IDLE) ? SLOT_W'(N_SLOTS - 1) : r_a;

  dec38_next_slot u_next_slot (
    .mask (mask),
    .cur  (w_cur),
    .nxt  (w_nxt),
    .wrap (w_wrap),
    .none (w_none)
  );

  // Sequencer FSM with its blank and dwell counters; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_a          <= '0;
      r_en         <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_blank_cnt  <= '0;
      r_dwell_cnt  <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !stop && !w_none) begin
            r_state     <= ST_BLANK;
            r_a         <= w_nxt;
            r_blank_cnt <= BLANK_INIT;
            r_busy      <= 1'b1;
            r_en        <= 1'b0;
          end
        end
        ST_BLANK: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_blank_cnt == 4'd0) begin
            r_state     <= ST_DRIVE;
            r_en        <= 1'b1;
            r_dwell_cnt <= dwell;
          end else begin
            r_blank_cnt <= r_blank_cnt - 4'd1;
          end
        end
        ST_DRIVE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_dwell_cnt == '0) begin
            // Last driven cycle: mask is sampled here to pick the next slot.
            r_en <= 1'b0;
            if (w_none) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state      <= ST_BLANK;
              r_a          <= w_nxt;
              r_blank_cnt  <= BLANK_INIT;
              r_frame_done <= w_wrap;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a           = r_a;
  assign en          = r_en;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule : dec38_scan_ctrl

// File: tb/tb_dec38_scan_ctrl.sv
// Self-checking bench for dec38_scan_ctrl. Expected behaviour is generated as a
// per-cycle trace from slot-level rules (slot order, blank/dwell lengths,
// wrap detection) and compared against the DUT on every falling clock edge.
module tb_dec38_scan_ctrl;

  localparam int TB_BLANK = 2;
  localparam int TB_DW    = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic             start;
  logic             stop;
  logic [TB_DW-1:0] dwell;
  logic [7:0]       mask;
  logic [2:0]       a;
  logic             en;
  logic             busy;
  logic             frame_done;
  logic [1:0]       dbg_state;

  dec38_scan_ctrl #(
    .DWELL_W      (TB_DW),
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .dwell       (dwell),
    .mask        (mask),
    .a           (a),
    .en          (en),
    .busy        (busy),
    .frame_done  (frame_done),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {state[1:0], a[2:0], en, busy, frame_done}
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_err;
  logic [2:0] last_a;

  function automatic logic [7:0] mk(input logic [1:0] st, input logic [2:0] av,
                                    input logic env, input logic bz, input logic fd);
    return {st, av, env, bz, fd};
  endfunction

  function automatic logic [7:0] observed();
    return {dbg_state, a, en, busy, frame_done};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs_v, input logic [7:0] exp_v);
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed st/a/en/busy/fd=%b expected %b", tag, obs_v, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // Next enabled slot after cur in circular ascending order (cur itself last).
  function automatic int next_slot_ref(input logic [7:0] m, input int cur);
    for (int d = 1; d <= 8; d++) begin
      int s;
      s = (cur + d) % 8;
      if (m[s]) return s;
    end
    return cur;
  endfunction

  // Expected trace of a scan started from IDLE. Mask switches from m0 to m1
  // after trace entry chg_idx (if >= 0); stop is raised after entry stop_idx.
  task automatic build(input logic [7:0] m0, input int dw, input int n_slots,
                       input int chg_idx, input logic [7:0] m1, input int stop_idx);
    int         slot;
    int         nxt;
    int         idx;
    logic       fd;
    logic [7:0] m;
    logic [2:0] a3;
    logic [7:0] e;
    exp_q.delete();
    idx  = 0;
    fd   = 1'b0;
    slot = next_slot_ref(m0, 7);
    for (int k = 0; k < n_slots; k++) begin
      a3 = 3'(slot);
      for (int j = 0; j < TB_BLANK; j++) begin
        exp_q.push_back(mk(2'd1, a3, 1'b0, 1'b1, (j == 0) && fd));
        idx++;
      end
      for (int j = 0; j <= dw; j++) begin
        exp_q.push_back(mk(2'd2, a3, 1'b1, 1'b1, 1'b0));
        idx++;
      end
      m = (chg_idx >= 0 && chg_idx <= idx - 1) ? m1 : m0;
      if (m == 8'h00) begin
        for (int j = 0; j < 3; j++) exp_q.push_back(mk(2'd0, a3, 1'b0, 1'b0, 1'b0));
        break;
      end
      nxt  = next_slot_ref(m, slot);
      fd   = (nxt <= slot);
      slot = nxt;
    end
    if (stop_idx >= 0 && stop_idx < exp_q.size()) begin
      e = exp_q[stop_idx];
      if (e[1]) begin
        a3 = e[5:3];
        while (exp_q.size() > stop_idx + 1) void'(exp_q.pop_back());
        for (int j = 0; j < 3; j++) exp_q.push_back(mk(2'd0, a3, 1'b0, 1'b0, 1'b0));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; raises start for exactly one rising edge.
  task automatic run_scan(input string tag, input logic [7:0] m0, input int dw,
                          input int n_slots, input int chg_idx, input logic [7:0] m1,
                          input int stop_idx);
    logic [7:0] e;
    int         i;
    build(m0, dw, n_slots, chg_idx, m1, stop_idx);
    mask  = m0;
    dwell = TB_DW'(dw);
    start = 1'b1;
    stop  = 1'b0;
    i     = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, i), observed(), e);
      last_a = e[5:3];
      if (i == chg_idx) mask = m1;
      if (i == stop_idx) stop = 1'b1;
      i++;
    end
    stop = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("%s[%0d]", tag, i), observed(), mk(2'd0, last_a, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    n_checks = 0;
    n_err    = 0;
    last_a   = 3'd0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    dwell    = '0;
    mask     = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", observed(), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;
    idle_cycles("post_reset_idle", 2);

    // Full scan: slots 0..7 twice, wrap pulse every 24 cycles
    run_scan("full_scan", 8'hFF, 0, 17, -1, 8'h00, 17 * 3 - 1);

    // Sparse mask alternating 2,5 with 4-cycle dwell
    run_scan("sparse", 8'b0010_0100, 3, 6, -1, 8'h00, 6 * 6 - 1);

    // Single slot: frame_done on every slot
    run_scan("single", 8'h80, 0, 5, -1, 8'h00, 5 * 3 - 1);

    // Empty mask ignores start
    mask  = 8'h00;
    start = 1'b1;
    idle_cycles("empty_mask", 4);
    start = 1'b0;

    // Stop in the 2nd DRIVE cycle of slot 3 (slot period 5, slot 3 drive at 17..19)
    run_scan("stop_slot3", 8'hFF, 2, 6, -1, 8'h00, 18);

    // start and stop together in IDLE
    mask  = 8'hFF;
    start = 1'b1;
    stop  = 1'b1;
    idle_cycles("start_stop_idle", 4);
    start = 1'b0;
    stop  = 1'b0;

    // mask FF -> 01 during slot 4 (slot period 4, slot 4 at 16..19)
    run_scan("mask_to_01", 8'hFF, 1, 8, 17, 8'h01, 29);

    // mask -> 0 during slot 1 drive: idle after that slot ends
    run_scan("mask_to_0", 8'hFF, 2, 4, 7, 8'h00, -1);

    // Randomized scans with optional mid-run mask change and a stop
    for (int r = 0; r < 8; r++) begin
      logic [7:0] m0;
      logic [7:0] m1;
      int         dw;
      int         ns;
      int         len;
      int         ci;
      int         si;
      m0  = 8'($urandom_range(1, 255));
      m1  = 8'($urandom_range(0, 255));
      dw  = $urandom_range(0, 4);
      ns  = $urandom_range(4, 12);
      len = ns * (TB_BLANK + dw + 1);
      ci  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      si  = $urandom_range(2, len - 1);
      run_scan($sformatf("rand%0d", r), m0, dw, ns, ci, m1, si);
    end

    // Asynchronous reset during DRIVE
    mask  = 8'h0C;
    dwell = TB_DW'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_pre0", observed(), mk(2'd1, 3'd2, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    check("rst_pre1", observed(), mk(2'd1, 3'd2, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    check("rst_pre2", observed(), mk(2'd2, 3'd2, 1'b1, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", observed(), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n  = 1'b1;
    last_a = 3'd0;
    idle_cycles("rst_release_idle", 4);

    // Scanning resumes normally once started again
    run_scan("after_reset", 8'h0C, 1, 4, -1, 8'h00, 4 * 4 - 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_dec38_scan_ctrl
